// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded ID-stage inputs, registered EX-stage copies and
// hazard-control outputs. The master side is the surrounding ID-stage logic.
interface id_ex_if #(
    parameter int DATA_W = 32
);
    logic              RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] RSdata_i, RTdata_i, SignExt_i;
    logic [4:0]        RSaddr_i, RTaddr_i, RDaddr_i;
    logic              flush_i, hold_i;

    logic              RegDst_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RSdata_o, RTdata_o, SignExt_o;
    logic [4:0]        RSaddr_o, RTaddr_o, RDaddr_o;
    logic              stall_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o;

    modport master (
        output RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i,
               ALUOp_i, RSdata_i, RTdata_i, SignExt_i, RSaddr_i, RTaddr_i, RDaddr_i,
               flush_i, hold_i,
        input  RegDst_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o,
               ALUOp_o, RSdata_o, RTdata_o, SignExt_o, RSaddr_o, RTaddr_o, RDaddr_o,
               stall_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o
    );

    modport slave (
        input  RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i,
               ALUOp_i, RSdata_i, RTdata_i, SignExt_i, RSaddr_i, RTaddr_i, RDaddr_i,
               flush_i, hold_i,
        output RegDst_o, ALUSrc_o, RegWrite_o, MemWrite_o, MemRead_o, MemtoReg_o,
               ALUOp_o, RSdata_o, RTdata_o, SignExt_o, RSaddr_o, RTaddr_o, RDaddr_o,
               stall_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic     clk_i,
    input logic     rst_i,
    id_ex_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] BUBBLE = 1'b1;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } ctl_t;

    logic [0:0]        state;
    ctl_t              ctl_q, ctl_d;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, sext_q;
    logic [4:0]        rs_addr_q, rt_addr_q, rd_addr_q;
    logic              stall, ifid_flush;

    // A bubble in EX carries MemRead=0, so a load stalls its consumer only once.
    assign stall = (state == RUN) & ctl_q.mem_read & (rt_addr_q != 5'd0) &
                   ((rt_addr_q == bus.RSaddr_i) | (rt_addr_q == bus.RTaddr_i));
    // A branch depending on the in-flight load is not trusted until the stall ends.
    assign ifid_flush = bus.flush_i & ~stall & ~bus.hold_i;

    assign bus.stall_o     = stall;
    assign bus.PCWrite_o   = ~(stall | bus.hold_i);
    assign bus.IFIDWrite_o = ~(stall | bus.hold_i);
    assign bus.IFIDFlush_o = ifid_flush;

    always_comb begin
        ctl_d = '{reg_dst:   bus.RegDst_i,   alu_src:    bus.ALUSrc_i,
                  reg_write: bus.RegWrite_i, mem_write:  bus.MemWrite_i,
                  mem_read:  bus.MemRead_i,  mem_to_reg: bus.MemtoReg_i,
                  alu_op:    bus.ALUOp_i};
        if (stall) ctl_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= BUBBLE;
            ctl_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            sext_q    <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
        end else if (!bus.hold_i) begin
            state     <= stall ? BUBBLE : RUN;
            ctl_q     <= ctl_d;
            rs_data_q <= bus.RSdata_i;
            rt_data_q <= bus.RTdata_i;
            sext_q    <= bus.SignExt_i;
            rs_addr_q <= bus.RSaddr_i;
            rt_addr_q <= bus.RTaddr_i;
            rd_addr_q <= bus.RDaddr_i;
        end
    end

    assign bus.RegDst_o   = ctl_q.reg_dst;
    assign bus.ALUSrc_o   = ctl_q.alu_src;
    assign bus.RegWrite_o = ctl_q.reg_write;
    assign bus.MemWrite_o = ctl_q.mem_write;
    assign bus.MemRead_o  = ctl_q.mem_read;
    assign bus.MemtoReg_o = ctl_q.mem_to_reg;
    assign bus.ALUOp_o    = ctl_q.alu_op;
    assign bus.RSdata_o   = rs_data_q;
    assign bus.RTdata_o   = rt_data_q;
    assign bus.SignExt_o  = sext_q;
    assign bus.RSaddr_o   = rs_addr_q;
    assign bus.RTaddr_o   = rt_addr_q;
    assign bus.RDaddr_o   = rd_addr_q;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && !bus.hold_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (ifid_flush && flush_cnt_o != '1)           flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the pipelined MIPS CPU. It sits directly downstream of the main decoder (`Control`) and the register file in the ID stage. It registers the decoded control bits, operands and register addresses into the EX stage. It also detects load-use hazards, generates the PC/IF-ID stall, and inserts bubbles on hazards and branch/jump flushes.

## Interface
Parameters:
- `DATA_W`, 32, operand width
- `CNT_W`, 16, statistics counter width (only used with `HAZARD_STATS_EN`)

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `RegDst_i`, `ALUSrc_i`, `RegWrite_i`, `MemWrite_i`, `MemRead_i`, `MemtoReg_i`  in  1 each  decoder control bits for the instruction in ID
- `ALUOp_i`  in  2  decoder ALU op class
- `RSdata_i`, `RTdata_i`, `SignExt_i`  in  DATA_W each  register file read data and sign-extended immediate
- `RSaddr_i`, `RTaddr_i`, `RDaddr_i`  in  5 each  inst[25:21], inst[20:16], inst[15:11]
- `flush_i`  in  1  taken branch/jump resolved in ID; squash the instruction in IF
- `hold_i`  in  1  global freeze (e.g. memory busy)
- `*_o` mirrors of every `*_i` above except `flush_i`/`hold_i`  out  same widths  EX-stage registered copies
- `stall_o`  out  1  load-use hazard (combinational)
- `PCWrite_o`, `IFIDWrite_o`  out  1 each  write enables for PC and the IF/ID register
- `IFIDFlush_o`  out  1  clear the IF/ID register
- `stall_cnt_o`, `flush_cnt_o`  out  CNT_W each  present only with `HAZARD_STATS_EN`

## Operation
- Hazard: `stall_o = MemRead_o & (RTaddr_o != 0) & ((RTaddr_o == RSaddr_i) | (RTaddr_o == RTaddr_i))`.
  - Both source fields are always compared. This is conservative: false stalls on I-type rt destinations are accepted.
- `PCWrite_o = IFIDWrite_o = ~(stall_o | hold_i)`.
- `IFIDFlush_o = flush_i & ~stall_o & ~hold_i`. A branch whose operands depend on an in-flight load is not trusted during the stall cycle.
- Register update per rising edge, in priority order:
  1. `hold_i`: all `*_o` hold their value.
  2. `stall_o`: insert bubble. `RegWrite_o`, `MemWrite_o`, `MemRead_o`, `MemtoReg_o`, `RegDst_o`, `ALUSrc_o` = 0 and `ALUOp_o` = 00. Data and address outputs load from inputs (don't care).
  3. Otherwise: all `*_o` load from `*_i`.
- `flush_i` does not bubble ID/EX. The branch/jump itself carries no RegWrite/MemWrite and passes through normally.
- Two-state view of the stage: RUN and BUBBLE.
  - RUN → BUBBLE when `stall_o & ~hold_i`.
  - BUBBLE → RUN on the next unheld edge.
  - The bubble clears `MemRead_o`, so a single load can never cause more than one consecutive stall cycle.

## Timing
- Reset (async, immediate): all `*_o` = 0, which is a bubble. `stall_o` = 0. `PCWrite_o`, `IFIDWrite_o` = 1. `IFIDFlush_o` = 0. Counters = 0.
- Latency: ID inputs appear on the outputs one cycle later.
- `stall_o`, `PCWrite_o`, `IFIDWrite_o`, `IFIDFlush_o` are combinational from the current inputs/state, valid in the same cycle.
- Load-use penalty: exactly one bubble per dependent load. No stall for a load followed by an independent instruction.
- `hold_i` during a stall: stall_o stays high and the bubble is deferred until `hold_i` drops.
- Reset asserted mid-stall: the outputs clear at once and the stall ends.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cnt_o` increments on each edge where a bubble is inserted.
  - `flush_cnt_o` increments on each edge where `IFIDFlush_o` = 1.
  - Both counters saturate at all-ones and are cleared by `rst_i`.
- Not defined: the counters and their ports are absent. Behaviour is otherwise identical.

## Test plan
- Reset: assert `rst_i` mid-cycle with `RegWrite_i` = 1 → all `*_o` = 0 immediately; `PCWrite_o` = 1.
- Passthrough: R-type with `RegDst_i`=1, `ALUOp_i`=10, `RSdata_i`=0x0000_0005 → next cycle `RegDst_o`=1, `ALUOp_o`=10, `RSdata_o`=0x5; `stall_o`=0 throughout.
- Load-use: `lw $2` in EX, `add $3,$2,$4` in ID → `stall_o`=1 and `PCWrite_o`=0 for 1 cycle; the next `*_o` is a bubble; `add` is registered on the following edge.
- $zero / independent load: `lw $0` followed by `add $3,$0,$1` → `stall_o`=0. `lw $2` followed by `add $3,$4,$5` → `stall_o`=0.
- Stall versus flush: `lw $2` in EX and `beq $2,$1` in ID with `flush_i`=1 → `IFIDFlush_o`=0 in the stall cycle and 1 in the next cycle. `flush_cnt_o` increments by 1 (with `HAZARD_STATS_EN`).
- Hold: `hold_i`=1 for 3 cycles during a load-use hazard → outputs frozen, `stall_o` stays 1; exactly one bubble after release; `stall_cnt_o`=1.
